mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (ram with its dcache) between the instruction-fetch requester (IF, read-only) and the load/store unit (LS, read/write).
- Sequences each access over a parameterised number of cycles, then returns the response to the requester that owns it.
- Round-robin arbitration when both requesters are pending; one access is in flight at a time.
- Sits between the pipeline front/back ends and the ram instance.

Parameters:
- LAT, 1, cycles spent in ACCESS per transaction; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > LAT.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF read request pending; held until accepted.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  32  IF fetch address.
- if_resp_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched word.
- ls_req_valid  in  1  LS request pending; held until accepted.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_we  in  1  1 = store, 0 = load.
- ls_funct  in  10  funct code from define.v (FUNC_LW/LH/LB/LHU/LBU/SW/SH/SB).
- ls_addr  in  32  LS address.
- ls_wdata  in  32  store data.
- ls_resp_valid  out  1  one-cycle pulse; load data returned or store completed.
- ls_rdata  out  32  load result; 0 for stores.
- mem_r_en  out  1  to ram r_en.
- mem_w_en  out  1  to ram w_en.
- mem_funct  out  10  to ram funct.
- mem_addr  out  32  to ram addr.
- mem_wdata  out  32  to ram wdata.
- mem_rdata  in  32  from ram rdata; combinational, valid while mem_r_en=1.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0, owner=IF, last_grant=IF.
  - All latched request fields and both rdata registers cleared to 0.
  - All outputs 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, grant selection:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted. After reset this means LS wins the first tie.
  - The granted requester's req_ready=1 combinationally in this cycle; the other requester's ready=0.
  - On the clock edge: latch addr, funct and wdata (IF: funct=FUNC_LW, we=0), set owner and last_grant, cnt=0, next state=ACCESS.
  - Neither valid: stay in IDLE.
  - req_ready is 0 in every state other than IDLE.
- ACCESS:
  - mem_addr, mem_funct and mem_wdata are driven from the latched fields, stable for all LAT cycles.
  - cnt increments each cycle; the last cycle is cnt==LAT-1.
  - Loads: mem_r_en=1 for all LAT cycles; mem_rdata is captured into the owner's rdata register on the last cycle.
  - Stores: mem_w_en=1 on the last cycle only, giving exactly one ram write per store. mem_r_en stays 0.
  - After the last cycle, next state=RESP.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle; its rdata holds the captured value (stores: 0).
  - mem_* outputs are 0.
  - Next state=IDLE.
- Latency and throughput:
  - Request acceptance to resp_valid takes LAT+1 cycles.
  - Maximum throughput is one transaction per LAT+2 cycles.
- rdata registers hold their value until the next capture for the same owner.
- Outputs of the non-owner are never disturbed.
- Requester rules:
  - A requester must not drop valid or change its fields before ready. Changes after acceptance have no effect on the in-flight access.
  - A new valid in the same cycle as resp_valid is legal; it is arbitrated in the following IDLE cycle.
- Reset mid-operation:
  - Abandon the transaction and return to IDLE.
  - No resp_valid is issued.
  - A store reset before its final ACCESS cycle performs no write.
- No address checking or alignment checking is done here; the ram applies its own address window.

Decomposition:
- The existing define.v supplies the FUNC_* constants.
- New shared defines: state encodings (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2) and owner encodings (OWN_IF=1'b0, OWN_LS=1'b1).
- Sub-module rr_arb2: a 2-input round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot grant.
  - Purely combinational; last_grant is held in the parent.
- FSM, counter and latches are in the top level.

Test Plan:
- Single IF read, LAT=1: if_addr=0x80000000, memory word 0x00000013 -> if_req_ready in cycle 0; mem_r_en=1 in cycle 1 with mem_funct=FUNC_LW; if_resp_valid and if_rdata=0x00000013 in cycle 2.
- LS store SB then LBU, LAT=3: store addr=0x80000104, wdata=0x000000A5 -> mem_w_en high exactly 1 cycle (3rd ACCESS cycle), ls_resp_valid at +4 with ls_rdata=0. Then LBU at the same address -> ls_rdata=0x000000A5. LB at the same address -> 0xFFFFFFA5.
- Simultaneous requests from reset, both held valid: grants go LS, IF, LS, IF; each resp_valid goes only to the matching owner; no cycle with both ready=1.
- Back-to-back LS requests with LAT=2: second ls_req_ready no earlier than 4 cycles after the first; throughput is one per 4 cycles.
- Reset mid-ACCESS of a store, LAT=4, rst asserted in ACCESS cycle 2: mem_w_en never asserted; no resp_valid; state IDLE next cycle; a following read returns the old memory value.
- Out-of-window address 0x00001000, LW: ls_resp_valid with ls_rdata=0; arbiter returns to IDLE normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the IF/LS data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [9:0] FUNC_LB  = 10'h000;
  localparam logic [9:0] FUNC_LH  = 10'h001;
  localparam logic [9:0] FUNC_LW  = 10'h002;
  localparam logic [9:0] FUNC_LBU = 10'h004;
  localparam logic [9:0] FUNC_LHU = 10'h005;
  localparam logic [9:0] FUNC_SB  = 10'h008;
  localparam logic [9:0] FUNC_SH  = 10'h009;
  localparam logic [9:0] FUNC_SW  = 10'h00A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef struct packed {
    logic        we;
    logic [9:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is granted.
// Combinational; bit 0 is IF, bit 1 is LS, and the last-grant state lives in the parent.
module mem_port_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single ram port between IF (read-only) and LS (read/write), one access in flight.
// Accept in IDLE, LAT cycles of ACCESS, one RESP cycle; ready is only ever raised in IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_we,
  input  logic [9:0]  ls_funct,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_resp_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [9:0]  mem_funct,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  mem_req_t         req_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      ls_rdata_q;
  logic [1:0]       grant;
  logic             in_access;
  logic             access_last;

  mem_port_arbiter_rr_arb2 u_arb (
    .req   ({ls_req_valid, if_req_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  assign in_access   = (state == ST_ACCESS);
  assign access_last = in_access && (cnt == CNT_LAST);

  // Ready is masked during reset so that every output reads 0 while rst is high.
  assign if_req_ready = !rst && (state == ST_IDLE) && grant[0];
  assign ls_req_ready = !rst && (state == ST_IDLE) && grant[1];

  // A store writes only on its final ACCESS cycle, so an abandoned store never reaches ram.
  assign mem_r_en  = in_access && !req_q.we;
  assign mem_w_en  = access_last && req_q.we;
  assign mem_funct = in_access ? req_q.funct : '0;
  assign mem_addr  = in_access ? req_q.addr  : '0;
  assign mem_wdata = in_access ? req_q.wdata : '0;

  assign if_resp_valid = (state == ST_RESP) && (owner == OWN_IF);
  assign ls_resp_valid = (state == ST_RESP) && (owner == OWN_LS);
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      req_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner      <= grant[1] ? OWN_LS : OWN_IF;
            last_grant <= grant[1] ? OWN_LS : OWN_IF;
            cnt        <= '0;
            state      <= ST_ACCESS;
            if (grant[1]) begin
              req_q <= '{we: ls_we, funct: ls_funct, addr: ls_addr, wdata: ls_wdata};
            end else begin
              req_q <= '{we: 1'b0, funct: FUNC_LW, addr: if_addr, wdata: 32'd0};
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_RESP;
            if (owner == OWN_LS) begin
              ls_rdata_q <= req_q.we ? 32'd0 : mem_rdata;
            end else begin
              if_rdata_q <= mem_rdata;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances (LAT 1,3,2,4) sharing one byte-addressed ram model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        if_req_valid  [4];
  logic        if_req_ready  [4];
  logic [31:0] if_addr       [4];
  logic        if_resp_valid [4];
  logic [31:0] if_rdata      [4];
  logic        ls_req_valid  [4];
  logic        ls_req_ready  [4];
  logic        ls_we         [4];
  logic [9:0]  ls_funct      [4];
  logic [31:0] ls_addr       [4];
  logic [31:0] ls_wdata      [4];
  logic        ls_resp_valid [4];
  logic [31:0] ls_rdata      [4];
  logic        mem_r_en      [4];
  logic        mem_w_en      [4];
  logic [9:0]  mem_funct     [4];
  logic [31:0] mem_addr      [4];
  logic [31:0] mem_wdata     [4];
  logic [7:0]  mem_b         [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ram window is 0x80000000..0x800003FF; anything outside reads 0 and ignores writes
  function automatic logic [31:0] ram_rd(input logic [31:0] a, input logic [9:0] f);
    logic [31:0] w;
    logic [9:0]  o;
    if (a[31:10] != 22'h200000) return 32'd0;
    o = a[9:0];
    w = {mem_b[o + 10'd3], mem_b[o + 10'd2], mem_b[o + 10'd1], mem_b[o]};
    case (f)
      FUNC_LB:  return {{24{w[7]}}, w[7:0]};
      FUNC_LBU: return {24'd0, w[7:0]};
      FUNC_LH:  return {{16{w[15]}}, w[15:0]};
      FUNC_LHU: return {16'd0, w[15:0]};
      default:  return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 1024; k++) mem_b[k] <= 8'h00;
      mem_b[0]   <= 8'h13;
      mem_b[512] <= 8'h78;
      mem_b[513] <= 8'h56;
      mem_b[514] <= 8'h34;
      mem_b[515] <= 8'h12;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_w_en[i] && mem_addr[i][31:10] == 22'h200000) begin
          mem_b[mem_addr[i][9:0]] <= mem_wdata[i][7:0];
          if (mem_funct[i] == FUNC_SH || mem_funct[i] == FUNC_SW)
            mem_b[mem_addr[i][9:0] + 10'd1] <= mem_wdata[i][15:8];
          if (mem_funct[i] == FUNC_SW) begin
            mem_b[mem_addr[i][9:0] + 10'd2] <= mem_wdata[i][23:16];
            mem_b[mem_addr[i][9:0] + 10'd3] <= mem_wdata[i][31:24];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    logic [31:0] rd;
    always_comb rd = mem_r_en[g] ? ram_rd(mem_addr[g], mem_funct[g]) : 32'd0;

    mem_port_arbiter #(.LAT(L), .CNT_W(4)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .if_req_valid  (if_req_valid[g]),
      .if_req_ready  (if_req_ready[g]),
      .if_addr       (if_addr[g]),
      .if_resp_valid (if_resp_valid[g]),
      .if_rdata      (if_rdata[g]),
      .ls_req_valid  (ls_req_valid[g]),
      .ls_req_ready  (ls_req_ready[g]),
      .ls_we         (ls_we[g]),
      .ls_funct      (ls_funct[g]),
      .ls_addr       (ls_addr[g]),
      .ls_wdata      (ls_wdata[g]),
      .ls_resp_valid (ls_resp_valid[g]),
      .ls_rdata      (ls_rdata[g]),
      .mem_r_en      (mem_r_en[g]),
      .mem_w_en      (mem_w_en[g]),
      .mem_funct     (mem_funct[g]),
      .mem_addr      (mem_addr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_rdata     (rd)
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction from an IDLE cycle; returns one cycle after RESP (back in IDLE).
  task automatic txn(input int i, input int lat, input bit is_ls, input bit we,
                     input logic [9:0] f, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp, input string tag);
    if (is_ls) begin
      ls_req_valid[i] = 1'b1;
      ls_we[i]        = we;
      ls_funct[i]     = f;
      ls_addr[i]      = a;
      ls_wdata[i]     = wd;
    end else begin
      if_req_valid[i] = 1'b1;
      if_addr[i]      = a;
    end
    #1;
    chk({tag, "_rdy"}, is_ls ? ls_req_ready[i] : if_req_ready[i], 1);
    chk({tag, "_other_rdy"}, is_ls ? if_req_ready[i] : ls_req_ready[i], 0);
    tick;
    ls_req_valid[i] = 1'b0;
    if_req_valid[i] = 1'b0;
    ls_addr[i]      = ~a;
    if_addr[i]      = ~a;
    ls_wdata[i]     = ~wd;
    #1;
    for (int c = 0; c < lat; c++) begin
      chk({tag, "_w_en"}, mem_w_en[i], (we && c == lat - 1) ? 1 : 0);
      chk({tag, "_r_en"}, mem_r_en[i], we ? 0 : 1);
      chk({tag, "_addr"}, mem_addr[i], a);
      chk({tag, "_funct"}, mem_funct[i], is_ls ? f : FUNC_LW);
      chk({tag, "_wdata"}, mem_wdata[i], is_ls ? wd : 32'd0);
      chk({tag, "_busy_rdy"}, {if_req_ready[i], ls_req_ready[i]}, 0);
      tick;
    end
    chk({tag, "_resp"}, is_ls ? ls_resp_valid[i] : if_resp_valid[i], 1);
    chk({tag, "_other_resp"}, is_ls ? if_resp_valid[i] : ls_resp_valid[i], 0);
    chk({tag, "_rdata"}, is_ls ? ls_rdata[i] : if_rdata[i], exp);
    chk({tag, "_resp_mem_off"}, {mem_r_en[i], mem_w_en[i]}, 0);
    tick;
    chk({tag, "_resp_pulse"}, is_ls ? ls_resp_valid[i] : if_resp_valid[i], 0);
    chk({tag, "_rdata_hold"}, is_ls ? ls_rdata[i] : if_rdata[i], exp);
  endtask

  initial begin
    bit exp_ls;
    rst      = 1'b1;
    mem_init = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_req_valid[i] = 1'b0;
      if_addr[i]      = 32'd0;
      ls_req_valid[i] = 1'b0;
      ls_we[i]        = 1'b0;
      ls_funct[i]     = FUNC_LW;
      ls_addr[i]      = 32'd0;
      ls_wdata[i]     = 32'd0;
    end
    tick;
    mem_init = 1'b0;
    tick;

    // outputs stay 0 under reset even with both requesters pending
    if_req_valid[0] = 1'b1;
    ls_req_valid[0] = 1'b1;
    #1;
    chk("rst_if_rdy", if_req_ready[0], 0);
    chk("rst_ls_rdy", ls_req_ready[0], 0);
    chk("rst_resp", {if_resp_valid[0], ls_resp_valid[0]}, 0);
    chk("rst_if_rdata", if_rdata[0], 0);
    chk("rst_ls_rdata", ls_rdata[0], 0);
    chk("rst_mem", {mem_r_en[0], mem_w_en[0], mem_funct[0]}, 0);
    chk("rst_mem_addr", mem_addr[0], 0);
    if_req_valid[0] = 1'b0;
    ls_req_valid[0] = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    txn(0, 1, 1'b0, 1'b0, FUNC_LW, 32'h8000_0000, 32'd0, 32'h0000_0013, "if_lw");

    txn(1, 3, 1'b1, 1'b1, FUNC_SB,  32'h8000_0104, 32'h0000_00A5, 32'd0,         "ls_sb");
    txn(1, 3, 1'b1, 1'b0, FUNC_LBU, 32'h8000_0104, 32'd0,         32'h0000_00A5, "ls_lbu");
    txn(1, 3, 1'b1, 1'b0, FUNC_LB,  32'h8000_0104, 32'd0,         32'hFFFF_FFA5, "ls_lb");

    // tie from reset on LAT=2: LS, IF, LS, IF
    if_req_valid[2] = 1'b1;
    if_addr[2]      = 32'h8000_0000;
    ls_req_valid[2] = 1'b1;
    ls_we[2]        = 1'b0;
    ls_funct[2]     = FUNC_LW;
    ls_addr[2]      = 32'h8000_0104;
    ls_wdata[2]     = 32'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_ls = (k % 2 == 0);
      chk("rr_ls_rdy", ls_req_ready[2], exp_ls ? 1 : 0);
      chk("rr_if_rdy", if_req_ready[2], exp_ls ? 0 : 1);
      for (int c = 0; c < 2; c++) begin
        tick;
        chk("rr_busy_rdy", {if_req_ready[2], ls_req_ready[2]}, 0);
      end
      tick;
      chk("rr_ls_resp", ls_resp_valid[2], exp_ls ? 1 : 0);
      chk("rr_if_resp", if_resp_valid[2], exp_ls ? 0 : 1);
      chk("rr_rdata", exp_ls ? ls_rdata[2] : if_rdata[2], exp_ls ? 32'h0000_00A5 : 32'h0000_0013);
      tick;
    end

    // LS alone and held: accepted once every LAT+2 = 4 cycles
    if_req_valid[2] = 1'b0;
    #1;
    for (int n = 0; n < 12; n++) begin
      chk("b2b_ls_rdy", ls_req_ready[2], (n % 4 == 0) ? 1 : 0);
      tick;
    end
    ls_req_valid[2] = 1'b0;
    tick;

    // reset in the second ACCESS cycle of a LAT=4 store
    ls_req_valid[3] = 1'b1;
    ls_we[3]        = 1'b1;
    ls_funct[3]     = FUNC_SW;
    ls_addr[3]      = 32'h8000_0200;
    ls_wdata[3]     = 32'hDEAD_BEEF;
    #1;
    chk("rs_rdy", ls_req_ready[3], 1);
    tick;
    ls_req_valid[3] = 1'b0;
    #1;
    chk("rs_acc0_w_en", mem_w_en[3], 0);
    chk("rs_acc0_addr", mem_addr[3], 32'h8000_0200);
    tick;
    rst = 1'b1;
    #1;
    chk("rs_acc1_w_en", mem_w_en[3], 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rs_after_w_en", mem_w_en[3], 0);
    chk("rs_after_resp", ls_resp_valid[3], 0);
    chk("rs_after_addr", mem_addr[3], 0);
    txn(3, 4, 1'b1, 1'b0, FUNC_LW, 32'h8000_0200, 32'd0, 32'h1234_5678, "rs_readback");

    txn(3, 4, 1'b1, 1'b0, FUNC_LW, 32'h0000_1000, 32'd0, 32'd0, "oow_lw");
    txn(3, 4, 1'b0, 1'b0, FUNC_LW, 32'h8000_0000, 32'd0, 32'h0000_0013, "oow_next_if");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
